// File: rtl/ota_density_monitor.sv
// ============================================================================
// ota_density_monitor
//   Windowed ones-density and edge count of a synchronized OTA comparator
//   output, with a hysteresis-filtered decision.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ota_density_monitor #(
  parameter int WIN_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       ota_in,
  input  logic [7:0] thresh_hi,
  input  logic [7:0] thresh_lo,
  output logic [7:0] density,
  output logic       dens_valid,
  output logic       decision,
  output logic [7:0] edge_cnt
);

  logic                sync1;
  logic                s;
  logic                s_prev;
  logic [WIN_LOG2-1:0] wcnt;
  logic [WIN_LOG2:0]   ones;
  logic [WIN_LOG2:0]   ones_next;
  logic [7:0]          edges;
  logic [7:0]          edges_next;
  logic [8:0]          scaled;
  logic [7:0]          dens_next;
  logic                edge_hit;
  logic                close;

  assign edge_hit   = s ^ s_prev;
  assign close      = ena && (&wcnt);
  assign ones_next  = ones + (WIN_LOG2+1)'(s);
  assign edges_next = (edge_hit && (edges != 8'hFF)) ? edges + 8'd1 : edges;

  // Normalize the window count to an 8-bit density; only a full window reaches 256.
  generate
    if (WIN_LOG2 < 8) begin : g_scale_up
      assign scaled = 9'(ones_next) << (8 - WIN_LOG2);
    end else begin : g_scale_down
      assign scaled = 9'(ones_next >> (WIN_LOG2 - 8));
    end
  endgenerate

  assign dens_next = scaled[8] ? 8'hFF : scaled[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      s          <= 1'b0;
      s_prev     <= 1'b0;
      wcnt       <= '0;
      ones       <= '0;
      edges      <= '0;
      density    <= '0;
      edge_cnt   <= '0;
      decision   <= 1'b0;
      dens_valid <= 1'b0;
    end else begin
      sync1      <= ota_in;
      s          <= sync1;
      s_prev     <= s;
      dens_valid <= close;
      if (ena) begin
        if (close) begin
          // The closing cycle's own sample is folded in via the *_next terms.
          wcnt     <= '0;
          ones     <= '0;
          edges    <= '0;
          density  <= dens_next;
          edge_cnt <= edges_next;
          if (dens_next >= thresh_hi) begin
            decision <= 1'b1;
          end else if (dens_next <= thresh_lo) begin
            decision <= 1'b0;
          end
        end else begin
          wcnt  <= wcnt + WIN_LOG2'(1);
          ones  <= ones_next;
          edges <= edges_next;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ota_density_monitor.md
OTA_DENSITY_MONITOR -- requirements
Module: ota_density_monitor

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 4, legal range 4..12, setting the window length to N = 2^WIN_LOG2 enabled cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port ena, input, 1 bit: measurement enable.
REQ-005 The block SHALL have port ota_in, input, 1 bit: the digital OTA output, asynchronous to clk.
REQ-006 The block SHALL have port thresh_hi, input, 8 bits: decision set threshold.
REQ-007 The block SHALL have port thresh_lo, input, 8 bits: decision clear threshold.
REQ-008 The block SHALL have port density, output, 8 bits: ones density of the last completed window.
REQ-009 The block SHALL have port dens_valid, output, 1 bit: one-cycle strobe marking an update of the window results.
REQ-010 The block SHALL have port decision, output, 1 bit: hysteresis-filtered comparator state.
REQ-011 The block SHALL have port edge_cnt, output, 8 bits: ota transitions in the last completed window.

Function
REQ-012 ota_in SHALL pass through a 2-flop synchronizer; its output s lags ota_in by 2 clk cycles.
REQ-013 A register s_prev SHALL capture s every cycle, whatever the value of ena.
REQ-014 On each cycle with ena=1, the window counter wcnt SHALL increment 0..N-1 and wrap to 0.
REQ-015 On each cycle with ena=1, the ones accumulator SHALL add s.
REQ-016 On each cycle with ena=1 and s != s_prev, the edge accumulator SHALL increment, saturating at 255.
REQ-017 On cycles with ena=0, wcnt and both accumulators SHALL hold; outputs SHALL hold and dens_valid SHALL be 0.
REQ-018 The window SHALL close on an enabled cycle with wcnt=N-1; that cycle's sample and edge SHALL be counted in the closing window.
REQ-019 The cycle after the window closes, density, edge_cnt and decision SHALL update and dens_valid SHALL be 1 for exactly that cycle.
REQ-020 The cycle after the window closes, wcnt and both accumulators SHALL restart from 0, with no lost samples between windows.
REQ-021 Density scaling SHALL be ones<<(8-WIN_LOG2) when WIN_LOG2<8.
REQ-022 Density scaling SHALL be ones>>(WIN_LOG2-8) when WIN_LOG2>=8.
REQ-023 A scaled result of 256 (all ones) SHALL saturate density to 255.
REQ-024 The ones accumulator SHALL be WIN_LOG2+1 bits wide so that no overflow occurs.
REQ-025 Decision update SHALL use the new density: density >= thresh_hi sets decision to 1.
REQ-026 Otherwise, density <= thresh_lo SHALL clear decision to 0; otherwise decision SHALL hold.
REQ-027 When both decision conditions are true (thresh_lo >= thresh_hi), the set condition SHALL take priority.
REQ-028 The thresholds SHALL be sampled only on the window-close cycle.
REQ-029 When a window closes while ena falls in the same cycle, that window SHALL still complete and strobe.

Reset
REQ-030 While rst=1, the synchronizer, s_prev, wcnt, accumulators, density, edge_cnt, decision and dens_valid SHALL all be 0 on the next clk edge.
REQ-031 rst SHALL override ena, including in the middle of a window; the partial window SHALL be discarded with no strobe.
REQ-032 After rst falls, the first enabled cycle SHALL be wcnt=0 of a fresh window.

Verification
REQ-033 WIN_LOG2=4, ota_in=1 held for 3+ cycles, ena rises at cycle k -> dens_valid at k+16 only, density=255, edge_cnt=0, decision=1 (thresh_hi=192, thresh_lo=64).
REQ-034 ota_in toggling every cycle since before ena rose -> density=128 and edge_cnt=16 per window; decision held at prior value (1 after REQ-033, 0 from reset).
REQ-035 Hysteresis: windows of all-ones, 50%, then all-zeros -> decision 1, 1, 0; density=64 with thresh_lo=64 -> decision 0.
REQ-036 ena low for 10 cycles mid-window with ota_in=1 -> strobe delayed by exactly 10 cycles, density still 255, no strobe while ena=0.
REQ-037 rst pulsed for 1 cycle at wcnt=9 -> all outputs 0 next cycle; next strobe exactly 16 enabled cycles after release.
REQ-038 WIN_LOG2=10, all-ones -> density=255 (saturated); 512 ones -> density=128; strobe every 1024 enabled cycles.
